// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: VGA scan-out fetch has absolute priority,
// host accesses fill the cycles with no video request.
module vga_fb_arbiter #(
    parameter int AW       = 19,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 800
) (
    input  logic          clk25,
    input  logic          clr,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_valid,
    output logic [DW-1:0] vid_data,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic          host_starve,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, VID, HOST} own_e;

    own_e          state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          starve_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [1:0]    tag_q;
    logic          vid_valid_q, host_rvalid_q;
    logic [DW-1:0] vid_data_q, host_rdata_q;
    logic          host_pend;

    // A request still high during its own grant cycle is the one being served.
    assign host_pend = host_req && (state_q != HOST);

    always_comb begin
        state_d = IDLE;
        if (vid_req) begin
            state_d = VID;
        end else if (host_pend) begin
            state_d = HOST;
        end
        cnt_d = '0;
        if (host_pend) begin
            cnt_d = (cnt_q == CW'(MAX_WAIT)) ? cnt_q : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk25) begin
        if (clr) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            starve_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            tag_q         <= '0;
            vid_valid_q   <= 1'b0;
            vid_data_q    <= '0;
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (cnt_d == CW'(MAX_WAIT)) begin
                starve_q <= 1'b1;
            end
            unique case (state_d)
                VID: begin
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= vid_addr;
                    mem_wdata_q <= '0;
                end
                HOST: begin
                    mem_we_q    <= host_we;
                    mem_addr_q  <= host_addr;
                    mem_wdata_q <= host_we ? host_wdata : '0;
                end
                default: begin
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                end
            endcase
            // Tag {vid,host} rides alongside the RAM's one-cycle read latency.
            tag_q         <= {state_q == VID, (state_q == HOST) && !mem_we_q};
            vid_valid_q   <= tag_q[1];
            host_rvalid_q <= tag_q[0];
            if (tag_q[1]) begin
                vid_data_q <= mem_rdata;
            end
            if (tag_q[0]) begin
                host_rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_en      = (state_q != IDLE);
    assign host_gnt    = (state_q == HOST);
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign vid_valid   = vid_valid_q;
    assign vid_data    = vid_data_q;
    assign host_rvalid = host_rvalid_q;
    assign host_rdata  = host_rdata_q;
    assign host_starve = starve_q;

endmodule
